// File: rtl/capture_tx_framer.sv
// Capture framer: samples an 8-bit bus at a fixed rate into a FIFO and streams mode/length/payload.
// Optional build macro CAPTURE_TEST_PATTERN_EN replaces sample_in with an incrementing byte counter.
module capture_tx_framer #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned SAMPLE_FREQ = 10_000_000,
  parameter int unsigned FIFO_AW     = 14,
  parameter logic [7:0]  MODE_BYTE   = 8'h00,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic [7:0]  sample_in,
  input  logic        arm,
  input  logic [31:0] capture_len,
  input  logic        tx_tready,
  output logic        tx_tvalid,
  output logic [7:0]  tx_tdata,
  output logic        tx_tlast,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned COUNTER_MAX = CLK_FREQ / SAMPLE_FREQ - 1;
  localparam int unsigned CntW        = (COUNTER_MAX > 0) ? $clog2(COUNTER_MAX + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        len_q, len_d;
  logic [2:0]         hdr_idx_q, hdr_idx_d;
  logic [31:0]        load_cnt_q, load_cnt_d;
  logic [31:0]        cap_cnt_q, cap_cnt_d;
  logic [CntW-1:0]    rate_q, rate_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d;
  logic [7:0]         tdata_q, tdata_d;
  logic [7:0]         mem_q [2**FIFO_AW];

  logic       fifo_we, fifo_empty, fifo_full, hs, load_payload;
  logic [7:0] sample_val, hdr_byte;

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [7:0] pat_q, pat_d;
  assign sample_val = pat_q;
`else
  assign sample_val = sample_in;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q + FIFO_AW'(1)) == rd_ptr_q);
  assign hs         = tvalid_q & tx_tready;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx_q)
      3'd1:    hdr_byte = len_q[7:0];
      3'd2:    hdr_byte = len_q[15:8];
      3'd3:    hdr_byte = len_q[23:16];
      3'd4:    hdr_byte = len_q[31:24];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    hdr_idx_d    = hdr_idx_q;
    load_cnt_d   = load_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    rate_d       = rate_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    busy_d       = busy_q;
    fifo_we      = 1'b0;
    load_payload = 1'b0;
`ifdef CAPTURE_TEST_PATTERN_EN
    pat_d        = pat_q;
`endif

    if (state_q == S_IDLE) begin
      if (arm && (capture_len != 32'd0)) begin
        state_d    = S_HDR;
        len_d      = capture_len;
        overflow_d = 1'b0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        rate_d     = '0;
        cap_cnt_d  = '0;
        load_cnt_d = '0;
        hdr_idx_d  = 3'd1;
        tvalid_d   = 1'b1;
        tdata_d    = MODE_BYTE;
        tlast_d    = 1'b0;
        busy_d     = 1'b1;
`ifdef CAPTURE_TEST_PATTERN_EN
        pat_d      = 8'h00;
`endif
      end
    end else begin
      // Sampling runs alongside emission; overflow ends it for the rest of the packet.
      if (rate_q == CntW'(COUNTER_MAX)) begin
        rate_d = '0;
        if ((cap_cnt_q < len_q) && !overflow_q) begin
          if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            fifo_we   = 1'b1;
            wr_ptr_d  = wr_ptr_q + FIFO_AW'(1);
            cap_cnt_d = cap_cnt_q + 32'd1;
`ifdef CAPTURE_TEST_PATTERN_EN
            pat_d     = pat_q + 8'd1;
`endif
          end
        end
      end else begin
        rate_d = rate_q + CntW'(1);
      end

      if (state_q == S_HDR) begin
        if (hs) begin
          if (hdr_idx_q == 3'd5) begin
            state_d      = S_DATA;
            load_payload = 1'b1;
          end else begin
            tdata_d   = hdr_byte;
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end else begin
        if (hs && tlast_q) begin
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
        end else if (hs || !tvalid_q) begin
          load_payload = 1'b1;
        end
      end

      // A sample written this cycle into an empty FIFO is forwarded straight to the output.
      if (load_payload) begin
        tvalid_d = 1'b1;
        if (!fifo_empty) begin
          tdata_d  = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else if (fifo_we) begin
          tdata_d  = sample_val;
          rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else if (overflow_q) begin
          tdata_d = FILL_BYTE;
        end else begin
          tvalid_d = 1'b0;
        end
        if (tvalid_d) begin
          tlast_d    = (load_cnt_q == len_q - 32'd1);
          load_cnt_d = load_cnt_q + 32'd1;
        end else begin
          tlast_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (fifo_we) begin
      mem_q[wr_ptr_q] <= sample_val;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      hdr_idx_q  <= '0;
      load_cnt_q <= '0;
      cap_cnt_q  <= '0;
      rate_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CAPTURE_TEST_PATTERN_EN
      pat_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hdr_idx_q  <= hdr_idx_d;
      load_cnt_q <= load_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      rate_q     <= rate_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
`ifdef CAPTURE_TEST_PATTERN_EN
      pat_q      <= pat_d;
`endif
    end
  end

  assign tx_tvalid = tvalid_q;
  assign tx_tdata  = tdata_q;
  assign tx_tlast  = tlast_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_capture_tx_framer.sv
// Scoreboard bench for capture_tx_framer: packets predicted from sample-tick arithmetic.
module tb_capture_tx_framer;

  localparam int unsigned Step = 10;    // COUNTER_MAX + 1 for 100 MHz / 10 MHz
  localparam int unsigned Cap  = 15;    // 2^FIFO_AW - 1 with FIFO_AW = 4
  localparam int unsigned TabN = 16384;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sample_in = 8'h00;
  logic        arm = 1'b0;
  logic [31:0] capture_len = 32'd0;
  logic        tx_tready = 1'b0;
  logic        tx_tvalid, tx_tlast, busy, overflow;
  logic [7:0]  tx_tdata;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [7:0]  tab [TabN];
  logic [8:0]  sb [$];

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  capture_tx_framer #(
    .CLK_FREQ   (100_000_000),
    .SAMPLE_FREQ(10_000_000),
    .FIFO_AW    (4),
    .MODE_BYTE  (8'h00),
    .FILL_BYTE  (8'hFF)
  ) dut (
    .clk100     (clk100),
    .rst        (rst),
    .sample_in  (sample_in),
    .arm        (arm),
    .capture_len(capture_len),
    .tx_tready  (tx_tready),
    .tx_tvalid  (tx_tvalid),
    .tx_tdata   (tx_tdata),
    .tx_tlast   (tx_tlast),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sample_in follows a fixed random table indexed by clock edge number.
  initial begin
    for (int i = 0; i < TabN; i++) tab[i] = 8'($urandom);
    forever begin
      @(negedge clk100);
      sample_in = tab[(cyc + 1) % TabN];
      case (rdy_mode)
        0:       tx_tready = 1'b0;
        1:       tx_tready = 1'b1;
        2:       tx_tready = ~tx_tready;
        default: tx_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Sample k of a packet armed at edge n is taken at edge n + (k+1)*Step.
  function automatic logic [7:0] sample_at(input int unsigned n, input int unsigned k);
`ifdef CAPTURE_TEST_PATTERN_EN
    return 8'(k);
`else
    return tab[(n + (k + 1) * Step) % TabN];
`endif
  endfunction

  task automatic push_packet(input int unsigned n, input logic [31:0] len, input int unsigned nreal);
    logic [7:0] d;
    sb.push_back({1'b0, 8'h00});
    for (int b = 0; b < 4; b++) sb.push_back({1'b0, len[8*b +: 8]});
    for (int unsigned k = 0; k < len; k++) begin
      d = (k < nreal) ? sample_at(n, k) : 8'hFF;
      sb.push_back({(k == len - 1), d});
    end
  endtask

  task automatic arm_packet(input logic [31:0] len, input int unsigned nreal, output int unsigned n);
    @(negedge clk100);
    arm = 1'b1;
    capture_len = len;
    n = cyc + 1;
    push_packet(n, len, nreal);
    @(negedge clk100);
    arm = 1'b0;
    capture_len = $urandom;
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk("arm_tvalid", {31'd0, tx_tvalid}, 32'd1);
    chk("arm_mode_byte", {24'd0, tx_tdata}, 32'h00);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (busy && i < limit) begin
      @(negedge clk100);
      i++;
    end
    chk("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk100);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk100);
  endtask

  // Monitor: pops one expected byte per handshake and checks stall stability.
  initial begin
    logic       hold;
    logic [8:0] hold_v, exp;
    hold = 1'b0;
    hold_v = '0;
    forever begin
      @(negedge clk100);
      #1;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) chk("stall_stable", {22'd0, tx_tvalid, tx_tlast, tx_tdata}, {22'd0, 1'b1, hold_v});
        if (tx_tvalid && tx_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_byte", {23'd0, tx_tlast, tx_tdata}, 32'h1ff);
          end else begin
            exp = sb.pop_front();
            chk("stream_byte", {23'd0, tx_tlast, tx_tdata}, {23'd0, exp});
          end
        end
        hold = tx_tvalid && !tx_tready;
        hold_v = {tx_tlast, tx_tdata};
      end
    end
  end

  initial begin
    int unsigned n;
    rst = 1'b1;
    repeat (3) @(negedge clk100);
    chk("rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, tx_tdata}, 32'd0);
    chk("rst_tlast", {31'd0, tx_tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    rdy_mode = 1;
    arm_packet(32'd3, 3, n);
    wait_idle(200);

    rdy_mode = 2;
    arm_packet(32'h0102, 32'h0102, n);
    wait_idle(4000);

    @(negedge clk100);
    arm = 1'b1;
    capture_len = 32'd0;
    repeat (4) @(negedge clk100);
    arm = 1'b0;
    chk("zero_len_busy", {31'd0, busy}, 32'd0);
    chk("zero_len_tvalid", {31'd0, tx_tvalid}, 32'd0);

    rdy_mode = 3;
    for (int p = 0; p < 5; p++) begin
      logic [31:0] len;
      len = $urandom_range(1, 40);
      arm_packet(len, len, n);
      if (p == 0) begin
        repeat (20) @(negedge clk100);
        arm = 1'b1;
        capture_len = 32'd7;
        @(negedge clk100);
        arm = 1'b0;
      end
      wait_idle(1500);
    end

    arm_packet(32'd300, 300, n);
    wait_idle(5000);

    rdy_mode = 0;
    repeat (2) @(negedge clk100);
    arm_packet(32'd32, Cap, n);
    wait_cyc(n + 15 * Step + 5);
    chk("ovf_before_16th", {31'd0, overflow}, 32'd0);
    wait_cyc(n + 20 * Step + 5);
    chk("ovf_after_16th", {31'd0, overflow}, 32'd1);
    rdy_mode = 1;
    wait_idle(500);

    rdy_mode = 0;
    repeat (2) @(negedge clk100);
    arm_packet(32'd40, Cap, n);
    wait_cyc(n + 20 * Step + 5);
    chk("ovf2_set", {31'd0, overflow}, 32'd1);
    rdy_mode = 1;
    repeat (10) @(negedge clk100);
    rdy_mode = 0;
    repeat (2) @(negedge clk100);
    rst = 1'b1;
    @(negedge clk100);
    rst = 1'b0;
    sb.delete();
    chk("abort_tvalid", {31'd0, tx_tvalid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_overflow", {31'd0, overflow}, 32'd0);

    rdy_mode = 3;
    arm_packet(32'd20, 20, n);
    wait_idle(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_tx_framer.md
# capture_tx_framer

Upstream counterpart of the DAC playback path: samples an 8-bit input bus at a fixed rate, buffers the samples in an internal FIFO and frames them as a packet on the FTDI 245-FIFO controller's tx AXI-stream (tx_tvalid/tx_tready/tx_tdata/tx_tlast). The packet format matches the host playback format: one mode byte, a 4-byte little-endian length, then the payload. The block sits in the clk100 domain between the capture pins and `ftdi_245fifo_top` tx inputs.

## Interface
- CLK_FREQ, 100_000_000: clk100 frequency in Hz.
- SAMPLE_FREQ, 10_000_000: sample rate in Hz; COUNTER_MAX = CLK_FREQ/SAMPLE_FREQ - 1 (integer ≥ 0).
- FIFO_AW, 14: FIFO address width; usable capacity is 2^FIFO_AW - 1 entries.
- MODE_BYTE, 8'h00: first header byte.
- FILL_BYTE, 8'hFF: payload substitute after overflow.

- clk100  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  8  capture bus, sampled on rate ticks.
- arm  in  1  start request (level, acted on when idle).
- capture_len  in  32  payload sample count, latched on accepted arm.
- tx_tready  in  1  stream ready from FTDI controller.
- tx_tvalid  out  1  stream valid.
- tx_tdata  out  8  stream byte.
- tx_tlast  out  1  final payload byte marker.
- busy  out  1  packet in progress.
- overflow  out  1  sticky: FIFO full at a sample tick.

## Operation
- States: S_IDLE, S_HDR, S_DATA.
- S_IDLE: arm=1 and capture_len≠0 accepted → latch capture_len into len_r, clear overflow, clear FIFO pointers, clear rate counter, sample counter, byte index; go S_HDR. arm with capture_len=0 ignored.
- S_HDR: emits MODE_BYTE, then len_r[7:0], [15:8], [23:16], [31:24]; each advances on handshake (tx_tvalid & tx_tready). After 5th handshake → S_DATA.
- S_DATA: emits len_r payload bytes; tx_tlast=1 only with the last. After last handshake → S_IDLE.
- Sampling runs in S_HDR and S_DATA, in parallel with emission: rate counter counts 0..COUNTER_MAX; at COUNTER_MAX (tick) one sample written if captured < len_r and FIFO not full. Sampling stops when captured = len_r.
- Overflow: tick with FIFO full and captured < len_r → overflow=1, sampling stops permanently for this packet. Framer drains the FIFO, then emits FILL_BYTE for every remaining payload byte; total length stays len_r.
- Payload byte source in S_DATA: FIFO head if not empty; FILL_BYTE if empty and overflow; otherwise tx_tvalid=0 (waiting for a sample).
- FIFO: full = (wr+1 == rd), empty = (wr == rd), pointers FIFO_AW bits, natural wrap.
- arm while busy ignored. rst at any time aborts the packet, returns to S_IDLE; no partial tlast.

## Timing
- Reset values: tx_tvalid=0, tx_tdata=0, tx_tlast=0, busy=0, overflow=0, state S_IDLE, FIFO empty.
- All outputs registered.
- Accepted arm at cycle N: busy=1 and tx_tvalid=1 with tx_tdata=MODE_BYTE at N+1.
- First sample written at tick on cycle N+1+COUNTER_MAX; subsequent ticks every COUNTER_MAX+1 cycles.
- tx_tdata/tx_tlast stable while tx_tvalid=1 & tx_tready=0; tx_tvalid never drops without a handshake.
- With tx_tready held high: one byte per cycle while data available; sample available in FIFO is presentable the cycle after its write.
- busy falls the cycle after the final handshake; a new arm is accepted on that same cycle.
- Simultaneous FIFO write and read in one cycle both take effect.

## Configuration
- CAPTURE_TEST_PATTERN_EN: defined → sample_in ignored; sample value is an 8-bit counter cleared on accepted arm and incremented after each written sample (0x00, 0x01, … wrapping at 0xFF). Undefined → samples are sample_in.

## Test plan
- COUNTER_MAX=9, tx_tready=1, arm with capture_len=3, sample_in=8'hA5 → bytes 00,03,00,00,00,A5,A5,A5; tlast only on 8th; busy low after.
- tx_tready toggling 1/0 each cycle, capture_len=0x0102 → header 00,02,01,00,00, 258 payload bytes, data stable during stalls.
- FIFO_AW=4, tx_tready=0 through 20 ticks, capture_len=32 → overflow=1 after 16th tick; on release 15 samples then 17×FF, tlast on 32nd payload byte.
- CAPTURE_TEST_PATTERN_EN defined, capture_len=300 → payload 00..FF then 00..2B.
- rst asserted mid-payload → next cycle tx_tvalid=0, busy=0, overflow=0; subsequent arm yields full correct packet.
- arm with capture_len=0, and arm pulsed during busy → both ignored, no extra bytes.
